// File: rtl/ddr_app_sequencer.sv
// Bridges one arbitrated 128-bit request onto the MIG 7-series user interface and
// returns a tagged response; single outstanding transaction in the ui_clk domain.
module ddr_app_sequencer #(
  parameter int unsigned ADDR_WIDTH = 28,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned RD_TIMEOUT = 255
) (
  input  logic                    clk_166M66,
  input  logic                    mcu_sys_rst,
  input  logic                    i_init_calib_complete,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic                    i_req_rw,
  input  logic [ADDR_WIDTH-1:0]   i_req_addr,
  input  logic [DATA_WIDTH-1:0]   i_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_req_wmask,
  input  logic [1:0]              i_req_tag,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic                    o_rsp_write,
  output logic                    o_rsp_err,
  output logic [1:0]              o_rsp_tag,
  output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
  output logic [ADDR_WIDTH-1:0]   o_app_addr,
  output logic [2:0]              o_app_cmd,
  output logic                    o_app_en,
  input  logic                    i_app_rdy,
  output logic [DATA_WIDTH-1:0]   o_app_wdf_data,
  output logic [DATA_WIDTH/8-1:0] o_app_wdf_mask,
  output logic                    o_app_wdf_wren,
  output logic                    o_app_wdf_end,
  input  logic                    i_app_wdf_rdy,
  input  logic [DATA_WIDTH-1:0]   i_app_rd_data,
  input  logic                    i_app_rd_data_valid,
  input  logic                    i_app_rd_data_end,
  output logic                    o_err_timeout,
  output logic                    o_err_stray
);

  localparam int unsigned MASK_W = DATA_WIDTH / 8;
  localparam int unsigned CNT_W  = 10;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);
  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  typedef enum logic [2:0] {
    WAIT_CALIB,
    IDLE,
    WRITE,
    RD_CMD,
    RD_WAIT,
    RESP
  } state_t;

  state_t              state_q, state_d;
  logic                cmd_done_q, cmd_done_d;
  logic                data_done_q, data_done_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          tag_q, tag_d;

  logic                req_ready_d;
  logic                rsp_valid_d;
  logic                rsp_write_d;
  logic                rsp_err_d;
  logic [1:0]          rsp_tag_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_d;
  logic [ADDR_WIDTH-1:0] app_addr_d;
  logic [2:0]          app_cmd_d;
  logic                app_en_d;
  logic [DATA_WIDTH-1:0] wdf_data_d;
  logic [MASK_W-1:0]   wdf_mask_d;
  logic                wdf_wren_d;
  logic                err_timeout_d;
  logic                err_stray_d;

  logic                cmd_hs;
  logic                data_hs;

  // Single-beat bursts: every valid beat is also the last one.
  logic unused_rd_end;
  assign unused_rd_end = i_app_rd_data_end;

  assign o_app_wdf_end = o_app_wdf_wren;
  assign cmd_hs        = o_app_en & i_app_rdy;
  assign data_hs       = o_app_wdf_wren & i_app_wdf_rdy;

  // Next-state and next-output logic; every register holds unless a state moves it.
  always_comb begin
    state_d       = state_q;
    cmd_done_d    = cmd_done_q;
    data_done_d   = data_done_q;
    cnt_d         = cnt_q;
    tag_d         = tag_q;
    req_ready_d   = 1'b0;
    rsp_valid_d   = o_rsp_valid;
    rsp_write_d   = o_rsp_write;
    rsp_err_d     = o_rsp_err;
    rsp_tag_d     = o_rsp_tag;
    rsp_rdata_d   = o_rsp_rdata;
    app_addr_d    = o_app_addr;
    app_cmd_d     = o_app_cmd;
    app_en_d      = o_app_en;
    wdf_data_d    = o_app_wdf_data;
    wdf_mask_d    = o_app_wdf_mask;
    wdf_wren_d    = o_app_wdf_wren;
    err_timeout_d = o_err_timeout;
    err_stray_d   = o_err_stray;

    if (i_app_rd_data_valid && (state_q != WAIT_CALIB) && (state_q != RD_WAIT)) begin
      err_stray_d = 1'b1;
    end

    case (state_q)
      WAIT_CALIB: begin
        if (i_init_calib_complete) begin
          state_d     = IDLE;
          req_ready_d = 1'b1;
        end
      end

      IDLE: begin
        if (i_req_valid && o_req_ready) begin
          app_addr_d  = i_req_addr;
          wdf_data_d  = i_req_wdata;
          wdf_mask_d  = i_req_wmask;
          tag_d       = i_req_tag;
          app_en_d    = 1'b1;
          cmd_done_d  = 1'b0;
          data_done_d = 1'b0;
          if (i_req_rw) begin
            state_d    = WRITE;
            app_cmd_d  = CMD_WR;
            wdf_wren_d = 1'b1;
          end else begin
            state_d    = RD_CMD;
            app_cmd_d  = CMD_RD;
          end
        end else if (!i_init_calib_complete) begin
          state_d = WAIT_CALIB;
        end else begin
          req_ready_d = ~o_rsp_valid;
        end
      end

      // Command and data channels complete independently, in any order.
      WRITE: begin
        if (cmd_hs) begin
          app_en_d   = 1'b0;
          cmd_done_d = 1'b1;
        end
        if (data_hs) begin
          wdf_wren_d  = 1'b0;
          data_done_d = 1'b1;
        end
        if ((cmd_done_q || cmd_hs) && (data_done_q || data_hs)) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_tag_d   = tag_q;
          rsp_rdata_d = '0;
        end
      end

      RD_CMD: begin
        if (cmd_hs) begin
          app_en_d = 1'b0;
          cnt_d    = '0;
          state_d  = RD_WAIT;
        end
      end

      // A beat arriving on the last counted cycle still wins over the timeout.
      RD_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (i_app_rd_data_valid) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_tag_d   = tag_q;
          rsp_rdata_d = i_app_rd_data;
        end else if (cnt_q == CNT_LAST) begin
          state_d       = RESP;
          rsp_valid_d   = 1'b1;
          rsp_write_d   = 1'b0;
          rsp_err_d     = 1'b1;
          rsp_tag_d     = tag_q;
          rsp_rdata_d   = '0;
          err_timeout_d = 1'b1;
        end
      end

      RESP: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = WAIT_CALIB;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_166M66) begin
    if (mcu_sys_rst) begin
      state_q        <= WAIT_CALIB;
      cmd_done_q     <= 1'b0;
      data_done_q    <= 1'b0;
      cnt_q          <= '0;
      tag_q          <= '0;
      o_req_ready    <= 1'b0;
      o_rsp_valid    <= 1'b0;
      o_rsp_write    <= 1'b0;
      o_rsp_err      <= 1'b0;
      o_rsp_tag      <= '0;
      o_rsp_rdata    <= '0;
      o_app_addr     <= '0;
      o_app_cmd      <= '0;
      o_app_en       <= 1'b0;
      o_app_wdf_data <= '0;
      o_app_wdf_mask <= '0;
      o_app_wdf_wren <= 1'b0;
      o_err_timeout  <= 1'b0;
      o_err_stray    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cmd_done_q     <= cmd_done_d;
      data_done_q    <= data_done_d;
      cnt_q          <= cnt_d;
      tag_q          <= tag_d;
      o_req_ready    <= req_ready_d;
      o_rsp_valid    <= rsp_valid_d;
      o_rsp_write    <= rsp_write_d;
      o_rsp_err      <= rsp_err_d;
      o_rsp_tag      <= rsp_tag_d;
      o_rsp_rdata    <= rsp_rdata_d;
      o_app_addr     <= app_addr_d;
      o_app_cmd      <= app_cmd_d;
      o_app_en       <= app_en_d;
      o_app_wdf_data <= wdf_data_d;
      o_app_wdf_mask <= wdf_mask_d;
      o_app_wdf_wren <= wdf_wren_d;
      o_err_timeout  <= err_timeout_d;
      o_err_stray    <= err_stray_d;
    end
  end

endmodule

// File: tb/tb_ddr_app_sequencer.sv
// Directed bench for ddr_app_sequencer (RD_TIMEOUT=8): calibration gate, split and
// joint write handshakes, stalled read, timeout, stray beats and mid-read reset.
module tb_ddr_app_sequencer;

  localparam int unsigned AW = 28;
  localparam int unsigned DW = 128;
  localparam int unsigned MW = DW / 8;

  logic          clk_166M66 = 1'b0;
  logic          mcu_sys_rst;
  logic          i_init_calib_complete;
  logic          i_req_valid;
  logic          o_req_ready;
  logic          i_req_rw;
  logic [AW-1:0] i_req_addr;
  logic [DW-1:0] i_req_wdata;
  logic [MW-1:0] i_req_wmask;
  logic [1:0]    i_req_tag;
  logic          o_rsp_valid;
  logic          i_rsp_ready;
  logic          o_rsp_write;
  logic          o_rsp_err;
  logic [1:0]    o_rsp_tag;
  logic [DW-1:0] o_rsp_rdata;
  logic [AW-1:0] o_app_addr;
  logic [2:0]    o_app_cmd;
  logic          o_app_en;
  logic          i_app_rdy;
  logic [DW-1:0] o_app_wdf_data;
  logic [MW-1:0] o_app_wdf_mask;
  logic          o_app_wdf_wren;
  logic          o_app_wdf_end;
  logic          i_app_wdf_rdy;
  logic [DW-1:0] i_app_rd_data;
  logic          i_app_rd_data_valid;
  logic          i_app_rd_data_end;
  logic          o_err_timeout;
  logic          o_err_stray;

  int n_checks = 0;
  int n_pass   = 0;

  logic [313:0] all_out;
  assign all_out = {o_req_ready, o_rsp_valid, o_rsp_write, o_rsp_err, o_rsp_tag, o_rsp_rdata,
                    o_app_addr, o_app_cmd, o_app_en, o_app_wdf_data, o_app_wdf_mask,
                    o_app_wdf_wren, o_app_wdf_end, o_err_timeout, o_err_stray};

  ddr_app_sequencer #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .RD_TIMEOUT(8)
  ) u_dut (
    .clk_166M66           (clk_166M66),
    .mcu_sys_rst          (mcu_sys_rst),
    .i_init_calib_complete(i_init_calib_complete),
    .i_req_valid          (i_req_valid),
    .o_req_ready          (o_req_ready),
    .i_req_rw             (i_req_rw),
    .i_req_addr           (i_req_addr),
    .i_req_wdata          (i_req_wdata),
    .i_req_wmask          (i_req_wmask),
    .i_req_tag            (i_req_tag),
    .o_rsp_valid          (o_rsp_valid),
    .i_rsp_ready          (i_rsp_ready),
    .o_rsp_write          (o_rsp_write),
    .o_rsp_err            (o_rsp_err),
    .o_rsp_tag            (o_rsp_tag),
    .o_rsp_rdata          (o_rsp_rdata),
    .o_app_addr           (o_app_addr),
    .o_app_cmd            (o_app_cmd),
    .o_app_en             (o_app_en),
    .i_app_rdy            (i_app_rdy),
    .o_app_wdf_data       (o_app_wdf_data),
    .o_app_wdf_mask       (o_app_wdf_mask),
    .o_app_wdf_wren       (o_app_wdf_wren),
    .o_app_wdf_end        (o_app_wdf_end),
    .i_app_wdf_rdy        (i_app_wdf_rdy),
    .i_app_rd_data        (i_app_rd_data),
    .i_app_rd_data_valid  (i_app_rd_data_valid),
    .i_app_rd_data_end    (i_app_rd_data_end),
    .o_err_timeout        (o_err_timeout),
    .o_err_stray          (o_err_stray)
  );

  always #5 clk_166M66 = ~clk_166M66;

  // Advance one clock and observe 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk_166M66);
    #1;
  endtask

  task automatic test_reset();
    mcu_sys_rst = 1'b1;
    step();
    step();
    n_checks++;
    if (all_out !== '0) $display("FAIL reset_outputs: got %h, expected 0", all_out);
    else n_pass++;
    mcu_sys_rst = 1'b0;
  endtask

  task automatic test_calib_gate();
    int bad;
    bad = 0;
    i_req_valid = 1'b1;
    i_req_rw    = 1'b1;
    i_req_addr  = 28'h0000040;
    i_req_wdata = 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA;
    i_req_wmask = 16'h00FF;
    i_req_tag   = 2'd3;
    for (int i = 0; i < 20; i++) begin
      step();
      if (o_req_ready !== 1'b0 || o_app_en !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL calib_gate_block: %0d cycles with ready/app_en set, expected 0", bad);
    else n_pass++;
    i_init_calib_complete = 1'b1;
    step();
    n_checks++;
    if (o_req_ready !== 1'b1 || o_app_en !== 1'b0)
      $display("FAIL calib_ready: ready=%b app_en=%b, expected 1/0", o_req_ready, o_app_en);
    else n_pass++;
    step();  // accept
    i_req_valid = 1'b0;
    n_checks++;
    if ({o_app_en, o_app_wdf_wren, o_app_wdf_end, o_app_cmd, o_req_ready} !== 7'b1110000 ||
        o_app_addr !== 28'h0000040 || o_app_wdf_mask !== 16'h00FF)
      $display("FAIL calib_accept: en=%b wren=%b end=%b cmd=%b ready=%b addr=%h mask=%h, expected 1/1/1/000/0 addr 0000040 mask 00ff",
               o_app_en, o_app_wdf_wren, o_app_wdf_end, o_app_cmd, o_req_ready, o_app_addr, o_app_wdf_mask);
    else n_pass++;
    i_app_rdy     = 1'b1;
    i_app_wdf_rdy = 1'b1;
    step();
    i_app_rdy     = 1'b0;
    i_app_wdf_rdy = 1'b0;
    n_checks++;
    if ({o_rsp_valid, o_rsp_write, o_rsp_err, o_rsp_tag, o_app_en, o_app_wdf_wren} !== 7'b1101100)
      $display("FAIL calib_write_rsp: valid=%b write=%b err=%b tag=%0d en=%b wren=%b, expected 1/1/0/3/0/0",
               o_rsp_valid, o_rsp_write, o_rsp_err, o_rsp_tag, o_app_en, o_app_wdf_wren);
    else n_pass++;
    i_rsp_ready = 1'b1;
    step();
    i_rsp_ready = 1'b0;
    n_checks++;
    if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1)
      $display("FAIL calib_rsp_done: valid=%b ready=%b, expected 0/1", o_rsp_valid, o_req_ready);
    else n_pass++;
  endtask

  task automatic test_write_split();
    int en_cycles;
    i_req_valid   = 1'b1;
    i_req_rw      = 1'b1;
    i_req_addr    = 28'h0000100;
    i_req_wdata   = 128'h0123456789ABCDEF0123456789ABCDEF;
    i_req_wmask   = 16'h0000;
    i_req_tag     = 2'd1;
    i_app_rdy     = 1'b0;
    i_app_wdf_rdy = 1'b1;
    step();  // accept
    i_req_valid = 1'b0;
    n_checks++;
    if (o_app_en !== 1'b1 || o_app_wdf_wren !== 1'b1 || o_app_wdf_end !== 1'b1 || o_app_cmd !== 3'b000 ||
        o_app_addr !== 28'h0000100 || o_app_wdf_data !== 128'h0123456789ABCDEF0123456789ABCDEF ||
        o_app_wdf_mask !== 16'h0000)
      $display("FAIL wr_issue: en=%b wren=%b end=%b cmd=%b addr=%h data=%h mask=%h",
               o_app_en, o_app_wdf_wren, o_app_wdf_end, o_app_cmd, o_app_addr, o_app_wdf_data, o_app_wdf_mask);
    else n_pass++;
    en_cycles = 1;
    step();  // data handshake
    i_app_wdf_rdy = 1'b0;
    n_checks++;
    if (o_app_wdf_wren !== 1'b0 || o_app_wdf_end !== 1'b0 || o_rsp_valid !== 1'b0)
      $display("FAIL wr_data_drop: wren=%b end=%b rsp_valid=%b, expected 0/0/0",
               o_app_wdf_wren, o_app_wdf_end, o_rsp_valid);
    else n_pass++;
    if (o_app_en === 1'b1) en_cycles++;
    step();
    if (o_app_en === 1'b1) en_cycles++;
    step();
    if (o_app_en === 1'b1) en_cycles++;
    n_checks++;
    if (o_app_cmd !== 3'b000 || o_app_addr !== 28'h0000100 || o_rsp_valid !== 1'b0)
      $display("FAIL wr_cmd_hold: cmd=%b addr=%h rsp_valid=%b, expected 000/0000100/0",
               o_app_cmd, o_app_addr, o_rsp_valid);
    else n_pass++;
    i_app_rdy = 1'b1;
    step();  // command handshake
    i_app_rdy = 1'b0;
    if (o_app_en === 1'b1) en_cycles++;
    n_checks++;
    if (en_cycles != 4 || o_app_en !== 1'b0)
      $display("FAIL wr_en_cycles: app_en high %0d cycles (now %b), expected 4 then 0", en_cycles, o_app_en);
    else n_pass++;
    n_checks++;
    if (o_rsp_valid !== 1'b1 || o_rsp_write !== 1'b1 || o_rsp_err !== 1'b0 || o_rsp_tag !== 2'd1 ||
        o_rsp_rdata !== '0)
      $display("FAIL wr_rsp: valid=%b write=%b err=%b tag=%0d rdata=%h, expected 1/1/0/1/0",
               o_rsp_valid, o_rsp_write, o_rsp_err, o_rsp_tag, o_rsp_rdata);
    else n_pass++;
    i_rsp_ready = 1'b1;
    step();
    i_rsp_ready = 1'b0;
    n_checks++;
    if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1)
      $display("FAIL wr_rsp_done: valid=%b ready=%b, expected 0/1", o_rsp_valid, o_req_ready);
    else n_pass++;
  endtask

  // Accept-to-beat latency of 12 cycles, 5 of them spent stalled on app_rdy.
  task automatic test_read_latency();
    int en_bad;
    int early;
    int unstable;
    logic [DW-1:0] exp_data;
    exp_data    = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    i_req_valid = 1'b1;
    i_req_rw    = 1'b0;
    i_req_addr  = 28'h0ABCDE0;
    i_req_tag   = 2'd2;
    i_app_rdy   = 1'b0;
    step();  // accept, edge 0
    i_req_valid = 1'b0;
    n_checks++;
    if (o_app_en !== 1'b1 || o_app_cmd !== 3'b001 || o_app_addr !== 28'h0ABCDE0 || o_app_wdf_wren !== 1'b0)
      $display("FAIL rd_issue: en=%b cmd=%b addr=%h wren=%b, expected 1/001/0abcde0/0",
               o_app_en, o_app_cmd, o_app_addr, o_app_wdf_wren);
    else n_pass++;
    en_bad = 0;
    for (int i = 1; i <= 5; i++) begin
      step();
      if (o_app_en !== 1'b1 || o_app_cmd !== 3'b001) en_bad++;
    end
    n_checks++;
    if (en_bad != 0) $display("FAIL rd_cmd_stall: %0d stalled cycles lost app_en/cmd, expected 0", en_bad);
    else n_pass++;
    i_app_rdy = 1'b1;
    step();  // command handshake, edge 6
    i_app_rdy = 1'b0;
    n_checks++;
    if (o_app_en !== 1'b0) $display("FAIL rd_en_drop: app_en=%b, expected 0", o_app_en);
    else n_pass++;
    early = 0;
    for (int i = 7; i <= 11; i++) begin
      step();
      if (o_rsp_valid !== 1'b0) early++;
    end
    i_app_rd_data       = exp_data;
    i_app_rd_data_valid = 1'b1;
    i_app_rd_data_end   = 1'b1;
    step();  // beat sampled, edge 12
    i_app_rd_data_valid = 1'b0;
    i_app_rd_data_end   = 1'b0;
    i_app_rd_data       = '0;
    n_checks++;
    if (early != 0) $display("FAIL rd_early_rsp: %0d early response cycles, expected 0", early);
    else n_pass++;
    n_checks++;
    if (o_rsp_valid !== 1'b1 || o_rsp_write !== 1'b0 || o_rsp_err !== 1'b0 || o_rsp_tag !== 2'd2 ||
        o_rsp_rdata !== exp_data)
      $display("FAIL rd_rsp: valid=%b write=%b err=%b tag=%0d rdata=%h, expected 1/0/0/2/%h",
               o_rsp_valid, o_rsp_write, o_rsp_err, o_rsp_tag, o_rsp_rdata, exp_data);
    else n_pass++;
    unstable = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== exp_data || o_rsp_tag !== 2'd2 || o_req_ready !== 1'b0)
        unstable++;
    end
    n_checks++;
    if (unstable != 0) $display("FAIL rd_rsp_hold: %0d unstable cycles under backpressure, expected 0", unstable);
    else n_pass++;
    i_rsp_ready = 1'b1;
    step();
    i_rsp_ready = 1'b0;
    n_checks++;
    if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1 || o_err_stray !== 1'b0 || o_err_timeout !== 1'b0)
      $display("FAIL rd_rsp_done: valid=%b ready=%b stray=%b timeout=%b, expected 0/1/0/0",
               o_rsp_valid, o_req_ready, o_err_stray, o_err_timeout);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int early;
    int extra;
    i_req_valid = 1'b1;
    i_req_rw    = 1'b0;
    i_req_addr  = 28'h0000200;
    i_req_tag   = 2'd3;
    i_app_rdy   = 1'b1;
    step();  // accept, edge 0
    i_req_valid = 1'b0;
    step();  // command handshake, edge 1
    i_app_rdy = 1'b0;
    early = 0;
    for (int i = 2; i <= 8; i++) begin
      step();
      if (o_rsp_valid !== 1'b0 || o_err_timeout !== 1'b0) early++;
    end
    n_checks++;
    if (early != 0) $display("FAIL to_early: %0d cycles with early response/timeout, expected 0", early);
    else n_pass++;
    step();  // edge 9, 8 cycles after command acceptance
    n_checks++;
    if (o_rsp_valid !== 1'b1 || o_rsp_err !== 1'b1 || o_rsp_write !== 1'b0 || o_rsp_tag !== 2'd3 ||
        o_rsp_rdata !== '0 || o_err_timeout !== 1'b1)
      $display("FAIL to_rsp: valid=%b err=%b write=%b tag=%0d rdata=%h timeout=%b, expected 1/1/0/3/0/1",
               o_rsp_valid, o_rsp_err, o_rsp_write, o_rsp_tag, o_rsp_rdata, o_err_timeout);
    else n_pass++;
    step();  // edge 10
    i_app_rd_data       = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;
    i_app_rd_data_valid = 1'b1;
    i_app_rd_data_end   = 1'b1;
    step();  // late beat sampled, edge 11
    i_app_rd_data_valid = 1'b0;
    i_app_rd_data_end   = 1'b0;
    n_checks++;
    if (o_err_stray !== 1'b1 || o_rsp_err !== 1'b1 || o_rsp_rdata !== '0)
      $display("FAIL to_stray: stray=%b rsp_err=%b rdata=%h, expected 1/1/0", o_err_stray, o_rsp_err, o_rsp_rdata);
    else n_pass++;
    i_rsp_ready = 1'b1;
    step();
    i_rsp_ready = 1'b0;
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (o_rsp_valid !== 1'b0) extra++;
    end
    n_checks++;
    if (extra != 0 || o_err_timeout !== 1'b1)
      $display("FAIL to_no_second_rsp: %0d extra response cycles, timeout=%b, expected 0/1", extra, o_err_timeout);
    else n_pass++;
  endtask

  task automatic test_same_cycle();
    int extra;
    logic [DW-1:0] exp_data;
    exp_data    = 128'h1357_9BDF_2468_ACE0_1122_3344_5566_7788;
    i_req_valid = 1'b1;
    i_req_rw    = 1'b0;
    i_req_addr  = 28'h0000300;
    i_req_tag   = 2'd1;
    i_app_rdy   = 1'b1;
    step();  // accept
    i_req_valid = 1'b0;
    step();  // command handshake
    i_app_rdy = 1'b0;
    for (int i = 2; i <= 8; i++) step();
    i_app_rd_data       = exp_data;
    i_app_rd_data_valid = 1'b1;
    i_app_rd_data_end   = 1'b1;
    step();  // beat on the timeout cycle
    i_app_rd_data_valid = 1'b0;
    i_app_rd_data_end   = 1'b0;
    n_checks++;
    if (o_rsp_valid !== 1'b1 || o_rsp_err !== 1'b0 || o_rsp_rdata !== exp_data || o_rsp_tag !== 2'd1)
      $display("FAIL same_rd_timeout: valid=%b err=%b tag=%0d rdata=%h, expected 1/0/1/%h",
               o_rsp_valid, o_rsp_err, o_rsp_tag, o_rsp_rdata, exp_data);
    else n_pass++;
    i_rsp_ready = 1'b1;
    step();
    i_rsp_ready = 1'b0;

    i_req_valid   = 1'b1;
    i_req_rw      = 1'b1;
    i_req_addr    = 28'h0000400;
    i_req_wdata   = 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5;
    i_req_wmask   = 16'hF00F;
    i_req_tag     = 2'd2;
    i_app_rdy     = 1'b1;
    i_app_wdf_rdy = 1'b1;
    step();  // accept
    i_req_valid = 1'b0;
    step();  // both handshakes together
    i_app_rdy     = 1'b0;
    i_app_wdf_rdy = 1'b0;
    n_checks++;
    if (o_rsp_valid !== 1'b1 || o_rsp_write !== 1'b1 || o_rsp_tag !== 2'd2 || o_app_en !== 1'b0 ||
        o_app_wdf_wren !== 1'b0)
      $display("FAIL same_wr_rsp: valid=%b write=%b tag=%0d en=%b wren=%b, expected 1/1/2/0/0",
               o_rsp_valid, o_rsp_write, o_rsp_tag, o_app_en, o_app_wdf_wren);
    else n_pass++;
    i_rsp_ready = 1'b1;
    step();
    i_rsp_ready = 1'b0;
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (o_rsp_valid !== 1'b0 || o_app_en !== 1'b0) extra++;
    end
    n_checks++;
    if (extra != 0) $display("FAIL same_wr_single: %0d cycles with second response/command, expected 0", extra);
    else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    i_req_valid = 1'b1;
    i_req_rw    = 1'b0;
    i_req_addr  = 28'h0000500;
    i_req_tag   = 2'd3;
    i_app_rdy   = 1'b1;
    step();  // accept
    i_req_valid = 1'b0;
    step();  // command handshake
    i_app_rdy = 1'b0;
    step();
    step();
    mcu_sys_rst = 1'b1;
    step();
    mcu_sys_rst = 1'b0;
    n_checks++;
    if (all_out !== '0) $display("FAIL rst_mid_read: got %h, expected 0", all_out);
    else n_pass++;
    i_app_rd_data       = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;
    i_app_rd_data_valid = 1'b1;
    i_app_rd_data_end   = 1'b1;
    step();  // beat seen while still waiting for calibration
    n_checks++;
    if (o_err_stray !== 1'b0 || o_req_ready !== 1'b1)
      $display("FAIL rst_calib_no_stray: stray=%b ready=%b, expected 0/1", o_err_stray, o_req_ready);
    else n_pass++;
    step();  // beat seen in IDLE
    i_app_rd_data_valid = 1'b0;
    i_app_rd_data_end   = 1'b0;
    step();
    n_checks++;
    if (o_err_stray !== 1'b1 || o_rsp_valid !== 1'b0 || o_app_en !== 1'b0 || o_err_timeout !== 1'b0)
      $display("FAIL rst_late_stray: stray=%b rsp_valid=%b app_en=%b timeout=%b, expected 1/0/0/0",
               o_err_stray, o_rsp_valid, o_app_en, o_err_timeout);
    else n_pass++;
  endtask

  initial begin
    mcu_sys_rst           = 1'b1;
    i_init_calib_complete = 1'b0;
    i_req_valid           = 1'b0;
    i_req_rw              = 1'b0;
    i_req_addr            = '0;
    i_req_wdata           = '0;
    i_req_wmask           = '0;
    i_req_tag             = '0;
    i_rsp_ready           = 1'b0;
    i_app_rdy             = 1'b0;
    i_app_wdf_rdy         = 1'b0;
    i_app_rd_data         = '0;
    i_app_rd_data_valid   = 1'b0;
    i_app_rd_data_end     = 1'b0;

    test_reset();
    test_calib_gate();
    test_write_split();
    test_read_latency();
    test_timeout();
    test_same_cycle();
    test_reset_mid_read();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
